// File: rtl/eth_helper_pkg.sv
// rtl/eth_helper_pkg.sv - shared state encoding, stream tag constants and strobe-beat sizing for the W-channel tap
package eth_helper_pkg;

    typedef enum logic [1:0] {
        META   = 2'd0,
        DATA   = 2'd1,
        STROBE = 2'd2
    } tap_state_e;

    localparam int              STREAM_TYPE_WIDTH_DEF = 3;
    localparam logic [2:0]      STREAM_TYPE_DEF       = 3'b011;

    // Each strobe beat holds the byte strobes of eight data beats.
    function automatic int strobe_beat_count(input int captured_beats);
        int n;
        n = (captured_beats + 7) / 8;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/w_strobe_packer.sv
// rtl/w_strobe_packer.sv - collects per-beat write strobes of one burst, counts beats and flags overflow
module w_strobe_packer #(
    parameter  int DATA_WIDTH = 128,
    parameter  int MAX_BURST  = 16,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int STORE_W    = MAX_BURST * STRB_W,
    localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               capture_i,
    input  logic [STRB_W-1:0]  wstrb_i,
    output logic [STORE_W-1:0] strobes_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               err_overflow_o
);

    logic [STORE_W-1:0] store_q, store_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    always_comb begin
        store_d = store_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            store_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (capture_i) begin
            // Once saturated, further beats are counted only as an overflow.
            if (cnt_q == CNT_W'(MAX_BURST)) begin
                ovf_d = 1'b1;
            end else begin
                for (int b = 0; b < MAX_BURST; b++) begin
                    if (cnt_q == CNT_W'(b)) begin
                        store_d[b*STRB_W +: STRB_W] = wstrb_i;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            store_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            store_q <= store_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign strobes_o      = store_q;
    assign count_o        = cnt_q;
    assign err_overflow_o = ovf_q;

endmodule

// File: rtl/axi_w_stream_tap.sv
// rtl/axi_w_stream_tap.sv - AXI W pass-through tap emitting metadata, data and strobe beats; AXI_W_STREAM_TAP_USER_EN adds wuser to metadata
module axi_w_stream_tap
    import eth_helper_pkg::*;
#(
    parameter int                           DATA_WIDTH        = 128,
    parameter int                           ID_WIDTH          = 32,
    parameter int                           USER_WIDTH        = 64,
    parameter int                           STREAM_TYPE_WIDTH = STREAM_TYPE_WIDTH_DEF,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = STREAM_TYPE_DEF,
    parameter int                           MAX_BURST         = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ready,
    output logic                    valid,
    output logic                    in_progress,
    output logic                    last,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    err_overflow,
    output logic [ID_WIDTH-1:0]     AXIM_wid,
    output logic [DATA_WIDTH-1:0]   AXIM_wdata,
    output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
    output logic                    AXIM_wlast,
    output logic [USER_WIDTH-1:0]   AXIM_wuser,
    output logic                    AXIM_wvalid,
    input  logic                    AXIM_wready,
    input  logic [ID_WIDTH-1:0]     AXIS_wid,
    input  logic [DATA_WIDTH-1:0]   AXIS_wdata,
    input  logic [DATA_WIDTH/8-1:0] AXIS_wstrb,
    input  logic                    AXIS_wlast,
    input  logic [USER_WIDTH-1:0]   AXIS_wuser,
    input  logic                    AXIS_wvalid,
    output logic                    AXIS_wready
);

    localparam int NW    = MAX_BURST / 8;
    localparam int K_W   = (NW > 1) ? $clog2(NW) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    if (STREAM_TYPE_WIDTH + USER_WIDTH + ID_WIDTH > DATA_WIDTH) begin : g_bad_meta_width
        $error("axi_w_stream_tap: metadata fields exceed DATA_WIDTH");
    end

    tap_state_e               state_q, state_d;
    logic [K_W-1:0]           k_q, k_d;
    logic                     pass, hs, last_beat;
    logic [NW*DATA_WIDTH-1:0] strobes;
    logic [CNT_W-1:0]         count;
    logic [DATA_WIDTH-1:0]    meta, strobe_word, data_c;

    assign AXIM_wid    = AXIS_wid;
    assign AXIM_wdata  = AXIS_wdata;
    assign AXIM_wstrb  = AXIS_wstrb;
    assign AXIM_wlast  = AXIS_wlast;
    assign AXIM_wuser  = AXIS_wuser;

    // The W channel only moves while a data beat can be emitted on the stream.
    assign pass        = reset | (ready & (state_q == DATA));
    assign AXIM_wvalid = AXIS_wvalid & pass;
    assign AXIS_wready = AXIM_wready & pass;

    assign valid       = ~reset & (((state_q != STROBE) & AXIS_wvalid & AXIM_wready)
                                   | (state_q == STROBE));
    assign hs          = valid & ready;
    assign in_progress = ~reset & (state_q != META);
    assign last_beat   = (state_q == STROBE) && (int'(k_q) == strobe_beat_count(int'(count)) - 1);
    assign last        = valid & last_beat;

    always_comb begin
        meta = '0;
        meta[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] = STREAM_TYPE;
        meta[ID_WIDTH-1:0] = AXIS_wid;
`ifdef AXI_W_STREAM_TAP_USER_EN
        meta[ID_WIDTH +: USER_WIDTH] = AXIS_wuser;
`endif
    end

    always_comb begin
        strobe_word = '0;
        for (int w = 0; w < NW; w++) begin
            if (k_q == K_W'(w)) begin
                strobe_word = strobes[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        data_c = '0;
        case (state_q)
            META:    data_c = meta;
            DATA:    data_c = AXIS_wdata;
            STROBE:  data_c = strobe_word;
            default: data_c = '0;
        endcase
    end

    assign data = valid ? data_c : '0;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (hs) begin
            case (state_q)
                META:   state_d = DATA;
                DATA: begin
                    if (AXIS_wlast) begin
                        state_d = STROBE;
                        k_d     = '0;
                    end
                end
                STROBE: begin
                    if (last_beat) begin
                        state_d = META;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
                default: state_d = META;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= META;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    w_strobe_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_packer (
        .clk            (clk),
        .reset          (reset),
        .clear_i        (hs && (state_q == META)),
        .capture_i      (hs && (state_q == DATA)),
        .wstrb_i        (AXIS_wstrb),
        .strobes_o      (strobes),
        .count_o        (count),
        .err_overflow_o (err_overflow)
    );

endmodule

// File: doc/axi_w_stream_tap.md
AXI_W_STREAM_TAP -- requirements
Module: axi_w_stream_tap

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- DATA_WIDTH, 128, AXI W data and stream width; power of two, at least 128.
- ID_WIDTH, 32, wid width.
- USER_WIDTH, 64, wuser width.
- STREAM_TYPE, 3'b011, tag placed in the metadata MSBs.
- STREAM_TYPE_WIDTH, 3, tag width.
- MAX_BURST, 16, beats per burst whose strobes are captured; a multiple of 8.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high reset.
- ready, in, 1, downstream stream arbiter accepts a beat.
- valid, out, 1, stream beat available.
- in_progress, out, 1, stream packet open; blocks other submodules.
- last, out, 1, final stream beat of the packet.
- data, out, DATA_WIDTH, stream beat.
- err_overflow, out, 1, burst exceeded MAX_BURST.
- AXIM_wid / wdata / wstrb / wlast / wuser / wvalid, out, widths per parameters, forwarded W channel.
- AXIM_wready, in, 1, forwarded W channel ready.
- AXIS_wid / wdata / wstrb / wlast / wuser / wvalid, in, widths per parameters, incoming W channel.
- AXIS_wready, out, 1, incoming W channel ready.

REQ-003 One clock; reset SHALL be synchronous and active-high.

Function
REQ-004 AXIM_wid/wdata/wstrb/wlast/wuser SHALL equal the AXIS_ counterparts combinationally.
REQ-005 AXIM_wvalid SHALL be AXIS_wvalid AND (reset OR (ready AND state==DATA)).
- AXIS_wready SHALL be AXIM_wready gated by the same term.
REQ-006 States SHALL be META, DATA and STROBE, with a stream handshake hs = valid AND ready.
- With no hs, the state SHALL hold; it SHALL NOT fall back to META.
REQ-007 valid SHALL be NOT reset AND ((state in {META, DATA} AND AXIS_wvalid AND AXIM_wready) OR state==STROBE).
REQ-008 In META, data SHALL be {STREAM_TYPE, zeros, USER field per REQ-016, AXIS_wid}.
- On hs: go to DATA, clear the beat counter, the strobe store and err_overflow.
REQ-009 In DATA, data SHALL be AXIS_wdata.
- On hs with beat index i < MAX_BURST: store AXIS_wstrb at strobe bits [i*DATA_WIDTH/8 +: DATA_WIDTH/8].
- The counter SHALL increment and saturate at MAX_BURST.
- On hs of beat index MAX_BURST or higher: strobes SHALL be dropped and err_overflow set, sticky until the next META hs.
- On hs with AXIS_wlast: go to STROBE with strobe-beat index k=0.
REQ-010 In STROBE, data SHALL be strobe bits [k*DATA_WIDTH +: DATA_WIDTH].
- Number of strobe beats N = ceil(captured_beats/8), minimum 1.
- last SHALL be 1 only when k==N-1; on that hs go to META, otherwise k increments.
REQ-011 in_progress SHALL be 1 when state is not META.
REQ-012 data SHALL be 0 whenever valid is 0.

Reset
REQ-013 While reset is asserted:
- state SHALL go to META, counters to 0, strobe store to 0, err_overflow to 0.
- valid, last, in_progress and data SHALL be 0.
- The W channel SHALL pass through ungated.
REQ-014 Reset asserted mid-DATA or mid-STROBE SHALL abort the packet; no last beat is emitted.

Configuration
REQ-015 Macro AXI_W_STREAM_TAP_USER_EN SHALL select the metadata content.
REQ-016 With AXI_W_STREAM_TAP_USER_EN defined, metadata bits [ID_WIDTH +: USER_WIDTH] SHALL carry AXIS_wuser of the first beat.
- Without it, those bits SHALL be 0.
- Elaboration SHALL fail if STREAM_TYPE_WIDTH+USER_WIDTH+ID_WIDTH > DATA_WIDTH.

Structure
REQ-017 Package eth_helper_pkg SHALL hold the state enum (META, DATA, STROBE), the STREAM_TYPE constants, and a function for the strobe-beat count.
REQ-018 Strobe storage, beat counter and overflow flag SHALL form sub-module w_strobe_packer; the FSM and muxing SHALL stay in the top module.

Verification
REQ-019 The bench SHALL cover these directed scenarios (DATA_WIDTH=128, MAX_BURST=16, ready=1 unless stated):
- 4-beat burst, wid=0x5, wstrb 0xFFFF, 0x00FF, 0xF0F0, 0x0001 -> 6 beats: metadata {3'b011, 0, 0x5}, 4 data beats, then strobe beat low 64 bits 0x0001_F0F0_00FF_FFFF; last only on beat 6.
- 9-beat burst, all wstrb 0xFFFF -> 2 strobe beats: the first is all ones; the second has bits [15:0]=0xFFFF and the rest 0; last on the second.
- ready low for 3 cycles mid-DATA -> AXIM_wvalid=0 and AXIS_wready=0, state held; resume with no lost or duplicated beat.
- 17-beat burst -> err_overflow=1 from the cycle after beat 17 hs; 2 strobe beats; err_overflow cleared by the next META hs.
- reset asserted during DATA beat 2 -> next cycle valid=0 and in_progress=0; W channel passes through; next burst starts with metadata.
- With USER_EN, wuser=0xDEAD_BEEF -> metadata bits [95:32]=0x0000_0000_DEAD_BEEF; without USER_EN -> those bits are 0.
